// File: rtl/std_bypass_responder.sv
// Responder for the std cache bypass handshake: accepts one uncached request,
// issues it as a single-beat memory access and returns byte-extracted data or an ack.
module std_bypass_responder #(
    parameter int ADDR_WIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [63:0]           wdata_i,
    input  logic [7:0]            be_i,
    input  logic [1:0]            size_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  gnt_o,
    output logic                  valid_o,
    output logic [63:0]           rdata_o,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_we_o,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [63:0]           mem_req_wdata_o,
    output logic [7:0]            mem_req_be_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [63:0]           mem_rsp_rdata_i,
    input  logic                  mem_rsp_err_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [63:0]           wdata_q;
    logic [7:0]            be_q;
    logic [1:0]            size_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [63:0]           rdata_q;
    logic                  err_q;
    logic                  drain_q;
    logic [CNT_W-1:0]      cnt_q;

    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        logic [2:0] align;
        case (size)
            2'd0:    align = 3'b000;
            2'd1:    align = 3'b001;
            2'd2:    align = 3'b011;
            default: align = 3'b111;
        endcase
        return |(off & align);
    endfunction

    // Shift of an 8-bit mask truncates naturally, dropping lanes past byte 7.
    function automatic logic [7:0] derive_be(input logic [7:0] be, input logic [1:0] size,
                                             input logic [2:0] off);
        return (be != 8'h00) ? be : (lane_mask(size) << off);
    endfunction

    function automatic logic [63:0] extract_rdata(input logic [63:0] data, input logic [1:0] size,
                                                  input logic [2:0] off);
        logic [63:0] keep;
        case (size)
            2'd0:    keep = 64'h0000_0000_0000_00FF;
            2'd1:    keep = 64'h0000_0000_0000_FFFF;
            2'd2:    keep = 64'h0000_0000_FFFF_FFFF;
            default: keep = '1;
        endcase
        return (data >> {off, 3'b000}) & keep;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        gnt_o           = 1'b0;
        valid_o         = 1'b0;
        mem_req_valid_o = 1'b0;
        busy_o          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                gnt_o = req_i & rst_ni;
                if (req_i) state_d = misaligned(addr_i[2:0], size_i) ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid_i || cnt_q == CNT_MAX) state_d = RESP;
            end
            RESP: begin
                valid_o = 1'b1;
                state_d = drain_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (mem_rsp_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction registers; a response arriving on the timeout cycle takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            id_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= derive_be(be_i, size_i, addr_i[2:0]);
                        size_q  <= size_i;
                        id_q    <= id_i;
                        rdata_q <= '0;
                        err_q   <= misaligned(addr_i[2:0], size_i);
                    end
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rsp_valid_i) begin
                        err_q   <= mem_rsp_err_i;
                        rdata_q <= we_q ? 64'h0 : extract_rdata(mem_rsp_rdata_i, size_q, addr_q[2:0]);
                    end else if (cnt_q == CNT_MAX) begin
                        err_q   <= 1'b1;
                        rdata_q <= '1;
                        drain_q <= 1'b1;
                    end
                end
                DRAIN: if (mem_rsp_valid_i) drain_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rdata_o         = rdata_q;
    assign rid_o           = id_q;
    assign err_o           = err_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_be_o    = be_q;

endmodule

// File: tb/tb_std_bypass_responder.sv
// Directed bench for std_bypass_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever valid_o is seen.
module tb_std_bypass_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i;
    logic [63:0] addr_i, wdata_i;
    logic [7:0]  be_i;
    logic [1:0]  size_i;
    logic [3:0]  id_i;
    logic        gnt_o, valid_o, err_o, busy_o;
    logic [63:0] rdata_o;
    logic [3:0]  rid_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
    logic [63:0] mem_req_addr_o, mem_req_wdata_o;
    logic [7:0]  mem_req_be_o;
    logic        mem_rsp_valid_i, mem_rsp_err_i;
    logic [63:0] mem_rsp_rdata_i;

    typedef struct packed {
        logic [63:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    std_bypass_responder #(.ADDR_WIDTH(64), .ID_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i), .id_i(id_i), .gnt_o(gnt_o),
        .valid_o(valid_o), .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o), .busy_o(busy_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
        .mem_rsp_err_i(mem_rsp_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] be, input logic [1:0] sz, input logic [3:0] id);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be; size_i = sz; id_i = id;
    endtask

    task automatic expect_rsp(input logic [63:0] rd, input logic [3:0] id, input logic err);
        rsp_t e;
        e.rdata = rd; e.rid = id; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_rid"}, rid_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_mvalid"}, mem_req_valid_o, 0);
        chk({tag, "_mwe"}, mem_req_we_o, 0);
        chk({tag, "_maddr"}, mem_req_addr_o, 0);
        chk({tag, "_mwdata"}, mem_req_wdata_o, 0);
        chk({tag, "_mbe"}, mem_req_be_o, 0);
    endtask

    // Read with ready and response on the earliest cycles; called at the gnt cycle.
    task automatic read_txn(input logic [63:0] a, input logic [1:0] sz, input logic [7:0] be,
                            input logic [3:0] id, input logic [63:0] exp_addr,
                            input logic [7:0] exp_be, input logic [63:0] mdata,
                            input logic merr, input logic [63:0] exp_rdata);
        drive(1'b0, a, 64'h0, be, sz, id);
        @(negedge clk_i);
        chk("rd_gnt", gnt_o, 1);
        expect_rsp(exp_rdata, id, merr);
        cyc();
        req_i = 1'b0; mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rd_mvalid", mem_req_valid_o, 1);
        chk("rd_maddr", mem_req_addr_o, exp_addr);
        chk("rd_mbe", mem_req_be_o, exp_be);
        chk("rd_mwe", mem_req_we_o, 0);
        cyc();
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = mdata; mem_rsp_err_i = merr;
        @(negedge clk_i);
        chk("rd_valid_early", valid_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
        @(negedge clk_i);
        chk("rd_valid_lat", valid_o, 1);
        cyc();
        @(negedge clk_i);
        chk("rd_idle", busy_o, 0);
    endtask

    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h rid %0d err %0d, none expected",
                         rdata_o, rid_o, err_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rdata_o, mon_e.rdata);
                chk("rsp_rid", 64'(rid_o), 64'(mon_e.rid));
                chk("rsp_err", err_o, mon_e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 64'h0; wdata_i = 64'h0;
        be_i = 8'h0; size_i = 2'd0; id_i = 4'h0; mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = 64'h0; mem_rsp_err_i = 1'b0;
        #3;
        chk_all_zero("reset");
        req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();

        // Aligned word read at offset 4
        read_txn(64'h1004, 2'd2, 8'h00, 4'h3, 64'h1000, 8'hF0,
                 64'hAABBCCDD_11223344, 1'b0, 64'h00000000_AABBCCDD);

        // Halfword write with three cycles of backpressure
        cyc();
        drive(1'b1, 64'h2002, 64'h0000_0000_BEEF_0000, 8'h00, 2'd1, 4'h5);
        @(negedge clk_i);
        chk("wr_gnt", gnt_o, 1);
        expect_rsp(64'h0, 4'h5, 1'b0);
        cyc();
        req_i = 1'b0; mem_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("wr_mvalid", mem_req_valid_o, 1);
            chk("wr_maddr", mem_req_addr_o, 64'h2000);
            chk("wr_mbe", mem_req_be_o, 8'h0C);
            chk("wr_mwdata", mem_req_wdata_o, 64'h0000_0000_BEEF_0000);
            chk("wr_mwe", mem_req_we_o, 1);
            cyc();
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        chk("wr_mvalid_acc", mem_req_valid_o, 1);
        cyc();
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 64'hFFFF_FFFF_1234_5678;
        @(negedge clk_i);
        chk("wr_mvalid_off", mem_req_valid_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("wr_valid_lat", valid_o, 1);
        cyc();

        // Misaligned word: error response next cycle, no memory access
        drive(1'b0, 64'h3003, 64'h0, 8'h00, 2'd2, 4'h7);
        @(negedge clk_i);
        chk("mis_gnt", gnt_o, 1);
        expect_rsp(64'h0, 4'h7, 1'b1);
        cyc();
        req_i = 1'b0;
        @(negedge clk_i);
        chk("mis_valid", valid_o, 1);
        chk("mis_mvalid", mem_req_valid_o, 0);
        cyc();
        @(negedge clk_i);
        chk("mis_idle", busy_o, 0);
        cyc();

        // Timeout after 8 WAIT cycles, then drain of the late response
        drive(1'b0, 64'h4000, 64'h0, 8'h00, 2'd3, 4'h9);
        @(negedge clk_i);
        chk("to_gnt", gnt_o, 1);
        expect_rsp(64'hFFFF_FFFF_FFFF_FFFF, 4'h9, 1'b1);
        cyc();
        req_i = 1'b0; mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        chk("to_mbe", mem_req_be_o, 8'hFF);
        cyc();
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("to_wait_novalid", valid_o, 0);
            cyc();
        end
        drive(1'b0, 64'h5008, 64'h0, 8'h00, 2'd3, 4'h2);
        @(negedge clk_i);
        chk("to_valid", valid_o, 1);
        chk("to_resp_nognt", gnt_o, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk_i);
            chk("drain_nognt", gnt_o, 0);
            chk("drain_busy", busy_o, 1);
        end
        cyc();
        mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 64'h5555_5555_5555_5555;
        @(negedge clk_i);
        chk("drain_rsp_nognt", gnt_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b0;

        // Held request granted right after the drain; memory returns an error
        read_txn(64'h5008, 2'd3, 8'h00, 4'h2, 64'h5008, 8'hFF,
                 64'h01234567_89ABCDEF, 1'b1, 64'h01234567_89ABCDEF);

        // Byte read at offset 5 with explicit strobes
        cyc();
        read_txn(64'h6005, 2'd0, 8'h80, 4'h4, 64'h6000, 8'h80,
                 64'h11223344_55667788, 1'b0, 64'h33);

        // Reset while waiting for a response
        cyc();
        drive(1'b0, 64'h7000, 64'h0, 8'h00, 2'd3, 4'h6);
        @(negedge clk_i);
        chk("rst_gnt", gnt_o, 1);
        cyc();
        req_i = 1'b0; mem_req_ready_i = 1'b1;
        cyc();
        mem_req_ready_i = 1'b0;
        cyc();
        drive(1'b0, 64'h7008, 64'h0, 8'h00, 2'd3, 4'h1);
        rst_ni = 1'b0;
        #1;
        chk_all_zero("midrst");
        req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        cyc();
        mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 64'hDEAD_BEEF;
        @(negedge clk_i);
        chk("stale_busy", busy_o, 0);
        cyc();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("stale_novalid", valid_o, 0);
        cyc();
        read_txn(64'h7010, 2'd3, 8'h00, 4'hA, 64'h7010, 8'hFF,
                 64'hCAFEF00D_12345678, 1'b0, 64'hCAFEF00D_12345678);

        cyc();
        cyc();
        @(negedge clk_i);
        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/std_bypass_responder.md
Name: std_bypass_responder

Overview:
- Responder end of the std cache bypass request/response handshake (req/gnt/valid/rdata).
- Accepts one uncached request at a time from a bypass initiator (miss unit, AMO path) and issues it as a single-beat access on a simple valid/ready memory port.
- Returns the byte-extracted read data, or a write acknowledge, with an id echo and an error flag.
- Guards against a hung memory with a response timeout and a drain of late responses.

Parameters:
- ADDR_WIDTH, 64, request/memory address width
- ID_WIDTH, 4, request id width
- TIMEOUT_CYCLES, 1024, WAIT cycles without response before an error response is returned (>=2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  bypass request
- we_i  in  1  1=write, 0=read
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  64  write data, already lane-aligned
- be_i  in  8  byte enables; 0 means derive from size/addr
- size_i  in  2  log2 bytes (0..3)
- id_i  in  ID_WIDTH  request id
- gnt_o  out  1  request accepted this cycle
- valid_o  out  1  response valid, one-cycle pulse
- rdata_o  out  64  read data, LSB-aligned
- rid_o  out  ID_WIDTH  id of the response
- err_o  out  1  response carries an error (qualified by valid_o)
- busy_o  out  1  FSM not in IDLE
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request ready
- mem_req_we_o  out  1  memory write
- mem_req_addr_o  out  ADDR_WIDTH  address with bits [2:0] cleared
- mem_req_wdata_o  out  64  write data
- mem_req_be_o  out  8  byte strobes
- mem_rsp_valid_i  in  1  memory response valid (always accepted)
- mem_rsp_rdata_i  in  64  memory read data
- mem_rsp_err_i  in  1  memory response error

Behaviour:
- Reset (async, rst_ni low): FSM=IDLE, timeout counter=0; all outputs 0 (gnt_o combinational, 0 while in reset). An in-flight transaction is abandoned and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - gnt_o = req_i. On req_i, register we/addr/wdata/be/size/id.
  - Misaligned (addr_i[2:0] not a multiple of 2**size_i): go RESP with err=1, rdata=0, no memory access.
  - Otherwise go ISSUE.
- Strobe derivation:
  - be_i!=0: used as given.
  - be_i==0: ((1<<(1<<size))-1) << addr[2:0], truncated to 8 bits.
- ISSUE:
  - mem_req_valid_o=1; fields driven from registers; fields stable while valid && !ready.
  - On mem_req_ready_i, go WAIT with counter cleared.
- WAIT:
  - Counter increments each cycle.
  - On mem_rsp_valid_i: capture the response, err=mem_rsp_err_i, go RESP.
  - Reads: rdata = mem_rsp_rdata_i >> (8*addr[2:0]), bytes at index >= 2**size zeroed. Writes: rdata=0.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response: go RESP with err=1, rdata=all-ones, and set the drain flag.
  - A response in the same cycle as the timeout wins; no drain is needed.
- RESP:
  - valid_o=1 with the registered rdata_o, rid_o, err_o for exactly one cycle.
  - Next state: DRAIN if the drain flag is set, else IDLE. gnt_o=0.
- DRAIN:
  - gnt_o=0. Wait for mem_rsp_valid_i, discard it, clear the drain flag, go IDLE.
  - No timeout applies in DRAIN.
- Only one outstanding transaction; gnt_o=0 in every state except IDLE.
- Latency, aligned access with ready and response on the earliest cycles:
  - gnt cycle 0; mem_req_valid_o cycle 1; mem_rsp_valid_i cycle 2; valid_o cycle 3.
  - Next gnt possible cycle 4.
- Misaligned request: gnt cycle 0, valid_o/err_o cycle 1.
- mem_rsp_valid_i outside WAIT/DRAIN is ignored.
- busy_o = (state != IDLE).

Test Plan:
- Aligned read: addr=0x1004, size=2, be=0, memory returns 0xAABBCCDD_11223344 -> mem_req_addr_o=0x1000, mem_req_be_o=0xF0; valid_o at cycle 3, rdata_o=0x00000000_AABBCCDD, err_o=0, rid_o=id.
- Write with backpressure: we=1, addr=0x2002, size=1, wdata=0x0000_0000_BEEF_0000, mem_req_ready_i low for 3 cycles -> request fields stable throughout, mem_req_be_o=0x0C; valid_o one cycle after the response, rdata_o=0.
- Misaligned: addr=0x3003, size=2 -> no mem_req_valid_o; valid_o at cycle 1 with err_o=1, rdata_o=0.
- Timeout + drain (TIMEOUT_CYCLES=8): no response -> valid_o, err_o=1, rdata_o=all-ones. A req_i held high gets gnt_o=0 until the late mem_rsp_valid_i is discarded; gnt_o=1 the following cycle.
- Memory error: mem_rsp_err_i=1 on a read -> valid_o with err_o=1.
- Reset mid-WAIT: rst_ni low -> all outputs 0 immediately. After release, a later stale mem_rsp_valid_i produces no valid_o, and a new request is granted normally.
